// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the issue scoreboard: decoded op set, op classification and FIFO entry.
package hazard_scoreboard_pkg;

   localparam int SB_DEPTH    = 4;
   localparam int SB_NUM_REGS = 32;
   localparam int SB_REG_W    = $clog2(SB_NUM_REGS);

   typedef enum logic [5:0] {
      OP_NOP,
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
      OP_SLL, OP_SRL, OP_SRA, OP_SLLI, OP_SRLI, OP_SRAI,
      OP_SLT, OP_SLTU, OP_SLTI, OP_SLTIU,
      OP_ADDW, OP_SUBW, OP_ADDIW, OP_SLLW, OP_SRLW, OP_SRAW,
      OP_SLLIW, OP_SRLIW, OP_SRAIW,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LD, OP_LWU,
      OP_SB, OP_SH, OP_SW, OP_SD,
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC,
      OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI,
      OP_ECALL, OP_MRET
   } instruction_type;

   typedef struct packed {
      logic writes;
      logic load;
      logic serial;
      logic forwardable;
   } op_class_t;

   typedef struct packed {
      logic [SB_REG_W-1:0] rd;
      logic                writes;
      logic                nofwd;
      logic                serial;
   } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/retire handshake bundle between the decode stage (master) and the scoreboard (slave).
interface hazard_scoreboard_if #(
   parameter int REG_W = hazard_scoreboard_pkg::SB_REG_W,
   parameter int CNT_W = $clog2(hazard_scoreboard_pkg::SB_DEPTH + 1)
);
   import hazard_scoreboard_pkg::*;

   logic             issue_valid;
   instruction_type  issue_op;
   logic [REG_W-1:0] issue_rd;
   logic [REG_W-1:0] issue_rs1;
   logic [REG_W-1:0] issue_rs2;
   logic             issue_ready;
   logic             retire_valid;
   logic             flush;
   logic             stall_raw;
   logic             stall_serial;
   logic             stall_full;
   logic [CNT_W-1:0] inflight_count;
   logic             underflow_err;

   modport master (
      output issue_valid, issue_op, issue_rd, issue_rs1, issue_rs2, retire_valid, flush,
      input  issue_ready, stall_raw, stall_serial, stall_full, inflight_count, underflow_err
   );

   modport slave (
      input  issue_valid, issue_op, issue_rd, issue_rs1, issue_rs2, retire_valid, flush,
      output issue_ready, stall_raw, stall_serial, stall_full, inflight_count, underflow_err
   );

endinterface

// File: rtl/hazard_scoreboard_op_class.sv
// Combinational op classifier (writes/load/serial/forwardable); shared with other pipeline stages.
module op_class_decode
   import hazard_scoreboard_pkg::*;
(
   input  instruction_type op_i,
   output op_class_t       cls_o
);

   always_comb begin
      cls_o = '0;
      case (op_i)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
         OP_SLL, OP_SRL, OP_SRA, OP_SLLI, OP_SRLI, OP_SRAI,
         OP_SLT, OP_SLTU, OP_SLTI, OP_SLTIU,
         OP_ADDW, OP_SUBW, OP_ADDIW, OP_SLLW, OP_SRLW, OP_SRAW,
         OP_SLLIW, OP_SRLIW, OP_SRAIW, OP_LUI: begin
            cls_o.writes      = 1'b1;
            cls_o.forwardable = 1'b1;
         end
         OP_AUIPC: cls_o.writes = 1'b1;
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LD, OP_LWU: begin
            cls_o.writes = 1'b1;
            cls_o.load   = 1'b1;
         end
         OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_ECALL, OP_MRET:
            cls_o.serial = 1'b1;
         OP_JAL, OP_JALR, OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI: begin
            cls_o.writes = 1'b1;
            cls_o.serial = 1'b1;
         end
         default: cls_o = '0;
      endcase
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order issue scoreboard: in-flight FIFO with per-register pending-writer counters.
// Optional SCOREBOARD_FORWARD_EN: RAW checks only non-forwardable producers (pend_nf).
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int DEPTH    = SB_DEPTH,
   parameter int NUM_REGS = SB_NUM_REGS,
   parameter int REG_W    = $clog2(NUM_REGS),
   parameter int CNT_W    = $clog2(DEPTH + 1)
) (
   input logic               clk,
   input logic               reset,
   hazard_scoreboard_if.slave sb
);

   localparam int PTR_W = $clog2(DEPTH);

   op_class_t        cls;
   logic             in_writes, in_nofwd;
   sb_entry_t        in_entry, head;
   logic [REG_W-1:0] head_rd;

   sb_entry_t        fifo_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] serial_cnt_q, serial_cnt_d;
   logic [CNT_W-1:0] pend_q [NUM_REGS];
   logic [CNT_W-1:0] pend_d [NUM_REGS];
`ifdef SCOREBOARD_FORWARD_EN
   logic [CNT_W-1:0] pend_nf_q [NUM_REGS];
   logic [CNT_W-1:0] pend_nf_d [NUM_REGS];
`endif
   logic             underflow_q;

   logic [CNT_W-1:0] rs1_pend, rs2_pend;
   logic             raw, serial_blk, full, ready, do_issue, do_retire;

   op_class_decode u_op_class (
      .op_i  (sb.issue_op),
      .cls_o (cls)
   );

   assign in_writes = cls.writes && (sb.issue_rd != '0);
   assign in_nofwd  = in_writes && (!cls.forwardable || cls.load);
   assign in_entry  = '{rd: SB_REG_W'(sb.issue_rd), writes: in_writes, nofwd: in_nofwd,
                        serial: cls.serial};
   assign head      = fifo_q[head_q];
   assign head_rd   = REG_W'(head.rd);

`ifdef SCOREBOARD_FORWARD_EN
   assign rs1_pend = pend_nf_q[sb.issue_rs1];
   assign rs2_pend = pend_nf_q[sb.issue_rs2];
`else
   logic unused_nofwd;
   assign unused_nofwd = head.nofwd;
   assign rs1_pend     = pend_q[sb.issue_rs1];
   assign rs2_pend     = pend_q[sb.issue_rs2];
`endif

   // Hazards look only at registered state, so a same-cycle retire never unblocks issue.
   assign raw        = ((sb.issue_rs1 != '0) && (rs1_pend != '0)) ||
                       ((sb.issue_rs2 != '0) && (rs2_pend != '0));
   assign serial_blk = (serial_cnt_q != '0) || (cls.serial && (count_q != '0));
   assign full       = (count_q == CNT_W'(DEPTH));
   assign ready      = !raw && !serial_blk && !full;

   assign do_issue  = sb.issue_valid && ready && !sb.flush;
   assign do_retire = sb.retire_valid && (count_q != '0) && !sb.flush;

   assign sb.issue_ready    = ready;
   assign sb.stall_raw      = sb.issue_valid && raw;
   assign sb.stall_serial   = sb.issue_valid && serial_blk;
   assign sb.stall_full     = sb.issue_valid && full;
   assign sb.inflight_count = count_q;
   assign sb.underflow_err  = underflow_q;

   always_comb begin
      head_d       = head_q + PTR_W'(do_retire);
      tail_d       = tail_q + PTR_W'(do_issue);
      count_d      = count_q + CNT_W'(do_issue) - CNT_W'(do_retire);
      serial_cnt_d = serial_cnt_q + CNT_W'(do_issue && in_entry.serial)
                                  - CNT_W'(do_retire && head.serial);
      for (int r = 0; r < NUM_REGS; r++) begin
         pend_d[r] = pend_q[r]
                   + CNT_W'(do_issue && in_writes && (sb.issue_rd == REG_W'(r)))
                   - CNT_W'(do_retire && head.writes && (head_rd == REG_W'(r)));
`ifdef SCOREBOARD_FORWARD_EN
         pend_nf_d[r] = pend_nf_q[r]
                      + CNT_W'(do_issue && in_nofwd && (sb.issue_rd == REG_W'(r)))
                      - CNT_W'(do_retire && head.nofwd && (head_rd == REG_W'(r)));
`endif
      end
      if (sb.flush) begin
         head_d       = '0;
         tail_d       = '0;
         count_d      = '0;
         serial_cnt_d = '0;
         for (int r = 0; r < NUM_REGS; r++) begin
            pend_d[r] = '0;
`ifdef SCOREBOARD_FORWARD_EN
            pend_nf_d[r] = '0;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         serial_cnt_q <= '0;
         underflow_q  <= 1'b0;
         for (int r = 0; r < NUM_REGS; r++) begin
            pend_q[r] <= '0;
`ifdef SCOREBOARD_FORWARD_EN
            pend_nf_q[r] <= '0;
`endif
         end
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         serial_cnt_q <= serial_cnt_d;
         for (int r = 0; r < NUM_REGS; r++) begin
            pend_q[r] <= pend_d[r];
`ifdef SCOREBOARD_FORWARD_EN
            pend_nf_q[r] <= pend_nf_d[r];
`endif
         end
         if (sb.retire_valid && (count_q == '0) && !sb.flush) underflow_q <= 1'b1;
      end
   end

   // Entry storage needs no reset: occupancy alone decides which slots are live.
   always_ff @(posedge clk) begin
      if (do_issue) fifo_q[tail_q] <= in_entry;
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (count_q <= CNT_W'(DEPTH));
         assert (serial_cnt_q <= CNT_W'(DEPTH));
         for (int r = 0; r < NUM_REGS; r++) begin
            assert (pend_q[r] <= CNT_W'(DEPTH));
`ifdef SCOREBOARD_FORWARD_EN
            assert (pend_nf_q[r] <= CNT_W'(DEPTH));
`endif
         end
      end
   end
`endif

endmodule
